// File: rtl/fetch_redirect_ctrl.sv
// Fetch PC sequencer for the stage0 fetch datapath.
// Owns the fetch PC, the execute/writeback epochs, fence/sfence sequencing
// and redirects that must wait behind a pending (unaccepted) fetch request.
module fetch_redirect_ctrl #(
    parameter int              XLEN       = 64,
    parameter logic [XLEN-1:0] RESET_PC   = 64'h1000,
    parameter int              INST_BYTES = 4
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            wb_flush_valid,
    input  logic [XLEN-1:0] wb_flush_pc,
    input  logic            wb_flush_fence,
    input  logic            wb_flush_sfence,
    input  logic            ex_redirect_valid,
    input  logic [XLEN-1:0] ex_redirect_pc,
    input  logic            bpu_pred_valid,
    input  logic            bpu_pred_taken,
    input  logic [XLEN-1:0] bpu_pred_target,
    output logic            fetch_req_valid,
    input  logic            fetch_req_ready,
    output logic [XLEN-1:0] fetch_req_pc,
    output logic [1:0]      fetch_req_epoch,
    output logic            fence_valid,
    output logic            sfence_valid,
    input  logic            fence_done,
    output logic            eepoch,
    output logic            wepoch
);

    typedef enum logic [2:0] {
        ST_BOOT   = 3'd0,
        ST_RUN    = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_FENCE  = 3'd3,
        ST_SFENCE = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            valid_q, valid_d;
    logic            fence_q, fence_d;
    logic            sfence_q, sfence_d;
    logic            eepoch_q, eepoch_d;
    logic            wepoch_q, wepoch_d;
    logic [1:0]      req_epoch_q, req_epoch_d;
    logic            dly_valid_q, dly_valid_d;
    logic [XLEN-1:0] dly_pc_q, dly_pc_d;
    logic [XLEN-1:0] fence_tgt_q, fence_tgt_d;
    logic            fence_is_s_q, fence_is_s_d;

    logic            fire_s;
    logic            pending_s;
    logic            wb_is_fence_s;

    assign fire_s        = valid_q & fetch_req_ready;
    assign pending_s     = valid_q & ~fetch_req_ready;
    assign wb_is_fence_s = wb_flush_fence | wb_flush_sfence;

    // Next-state, next-PC and epoch computation for every state.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        eepoch_d     = eepoch_q;
        wepoch_d     = wepoch_q;
        dly_valid_d  = dly_valid_q;
        dly_pc_d     = dly_pc_q;
        fence_tgt_d  = fence_tgt_q;
        fence_is_s_d = fence_is_s_q;

        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (wb_flush_valid) begin
                    // A writeback flush wins over everything, including a
                    // simultaneous execute redirect whose target is dropped.
                    wepoch_d = ~wepoch_q;
                    if (wb_is_fence_s) begin
                        fence_tgt_d  = wb_flush_pc;
                        fence_is_s_d = wb_flush_sfence;
                        dly_valid_d  = 1'b0;
                        if (pending_s) begin
                            state_d = ST_DRAIN;
                        end else begin
                            state_d = wb_flush_sfence ? ST_SFENCE : ST_FENCE;
                        end
                    end else if (pending_s) begin
                        dly_valid_d = 1'b1;
                        dly_pc_d    = wb_flush_pc;
                    end else begin
                        pc_d        = wb_flush_pc;
                        dly_valid_d = 1'b0;
                    end
                end else if (ex_redirect_valid) begin
                    eepoch_d = ~eepoch_q;
                    if (pending_s) begin
                        dly_valid_d = 1'b1;
                        dly_pc_d    = ex_redirect_pc;
                    end else begin
                        pc_d        = ex_redirect_pc;
                        dly_valid_d = 1'b0;
                    end
                end else if (dly_valid_q) begin
                    // Stored redirect replaces the BPU/sequential update once
                    // the stale request has been accepted.
                    if (fire_s) begin
                        pc_d        = dly_pc_q;
                        dly_valid_d = 1'b0;
                    end else begin
                        pc_d = pc_q;
                    end
                end else if (fire_s && bpu_pred_valid && bpu_pred_taken) begin
                    pc_d = bpu_pred_target;
                end else if (fire_s) begin
                    pc_d = pc_q + XLEN'(INST_BYTES);
                end else begin
                    pc_d = pc_q;
                end
            end
            ST_DRAIN: begin
                if (fire_s) begin
                    state_d = fence_is_s_q ? ST_SFENCE : ST_FENCE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_FENCE, ST_SFENCE: begin
                if (fence_done) begin
                    state_d = ST_RUN;
                    pc_d    = fence_tgt_q;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase

        valid_d  = (state_d == ST_RUN) || (state_d == ST_DRAIN);
        fence_d  = (state_d == ST_FENCE);
        sfence_d = (state_d == ST_SFENCE);

        // A held request keeps the tag it was first presented with.
        if (pending_s) begin
            req_epoch_d = req_epoch_q;
        end else begin
            req_epoch_d = {wepoch_d, eepoch_d};
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q      <= ST_BOOT;
            pc_q         <= RESET_PC;
            valid_q      <= 1'b0;
            fence_q      <= 1'b0;
            sfence_q     <= 1'b0;
            eepoch_q     <= 1'b0;
            wepoch_q     <= 1'b0;
            req_epoch_q  <= 2'b00;
            dly_valid_q  <= 1'b0;
            dly_pc_q     <= '0;
            fence_tgt_q  <= '0;
            fence_is_s_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            valid_q      <= valid_d;
            fence_q      <= fence_d;
            sfence_q     <= sfence_d;
            eepoch_q     <= eepoch_d;
            wepoch_q     <= wepoch_d;
            req_epoch_q  <= req_epoch_d;
            dly_valid_q  <= dly_valid_d;
            dly_pc_q     <= dly_pc_d;
            fence_tgt_q  <= fence_tgt_d;
            fence_is_s_q <= fence_is_s_d;
        end
    end

    assign fetch_req_valid = valid_q;
    assign fetch_req_pc    = pc_q;
    assign fetch_req_epoch = req_epoch_q;
    assign fence_valid     = fence_q;
    assign sfence_valid    = sfence_q;
    assign eepoch          = eepoch_q;
    assign wepoch          = wepoch_q;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Scoreboard bench for fetch_redirect_ctrl: the stimulus pushes the expected
// {pc, epoch} of every accepted fetch; a negedge monitor pops on each fire.
module tb_fetch_redirect_ctrl;

    logic        CLK;
    logic        RST_N;
    logic        wb_flush_valid;
    logic [63:0] wb_flush_pc;
    logic        wb_flush_fence;
    logic        wb_flush_sfence;
    logic        ex_redirect_valid;
    logic [63:0] ex_redirect_pc;
    logic        bpu_pred_valid;
    logic        bpu_pred_taken;
    logic [63:0] bpu_pred_target;
    logic        fetch_req_valid;
    logic        fetch_req_ready;
    logic [63:0] fetch_req_pc;
    logic [1:0]  fetch_req_epoch;
    logic        fence_valid;
    logic        sfence_valid;
    logic        fence_done;
    logic        eepoch;
    logic        wepoch;

    typedef struct {
        logic [63:0] pc;
        logic [1:0]  ep;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    fetch_redirect_ctrl dut (
        .CLK               (CLK),
        .RST_N             (RST_N),
        .wb_flush_valid    (wb_flush_valid),
        .wb_flush_pc       (wb_flush_pc),
        .wb_flush_fence    (wb_flush_fence),
        .wb_flush_sfence   (wb_flush_sfence),
        .ex_redirect_valid (ex_redirect_valid),
        .ex_redirect_pc    (ex_redirect_pc),
        .bpu_pred_valid    (bpu_pred_valid),
        .bpu_pred_taken    (bpu_pred_taken),
        .bpu_pred_target   (bpu_pred_target),
        .fetch_req_valid   (fetch_req_valid),
        .fetch_req_ready   (fetch_req_ready),
        .fetch_req_pc      (fetch_req_pc),
        .fetch_req_epoch   (fetch_req_epoch),
        .fence_valid       (fence_valid),
        .sfence_valid      (sfence_valid),
        .fence_done        (fence_done),
        .eepoch            (eepoch),
        .wepoch            (wepoch)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock cycle: apply ready, record an expected fire, then clear pulses.
    task automatic cyc(input logic rdy, input logic ef, input logic [63:0] epc, input logic [1:0] eep);
        exp_t e;
        fetch_req_ready = rdy;
        if (ef) begin
            e.pc = epc;
            e.ep = eep;
            exp_q.push_back(e);
        end
        @(posedge CLK);
        #1;
        wb_flush_valid    = 1'b0;
        wb_flush_fence    = 1'b0;
        wb_flush_sfence   = 1'b0;
        ex_redirect_valid = 1'b0;
        bpu_pred_valid    = 1'b0;
        bpu_pred_taken    = 1'b0;
        fence_done        = 1'b0;
    endtask

    // Monitor: every accepted request is compared against the scoreboard.
    always @(negedge CLK) begin
        exp_t e;
        if (RST_N && fetch_req_valid && fetch_req_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_fire: got pc 0x%0h epoch %b, no request expected",
                         fetch_req_pc, fetch_req_epoch);
            end else begin
                e = exp_q.pop_front();
                if (fetch_req_pc !== e.pc || fetch_req_epoch !== e.ep) begin
                    errors++;
                    $display("FAIL fire: got pc 0x%0h epoch %b expected pc 0x%0h epoch %b",
                             fetch_req_pc, fetch_req_epoch, e.pc, e.ep);
                end
            end
        end
        if (RST_N && wb_flush_valid && (fence_valid || sfence_valid)) begin
            errors++;
            $display("FAIL illegal_flush: wb flush during fence got 1 expected 0");
        end
    end

    initial begin
        RST_N = 1'b0;
        wb_flush_valid = 1'b0; wb_flush_pc = 64'h0; wb_flush_fence = 1'b0; wb_flush_sfence = 1'b0;
        ex_redirect_valid = 1'b0; ex_redirect_pc = 64'h0;
        bpu_pred_valid = 1'b0; bpu_pred_taken = 1'b0; bpu_pred_target = 64'h0;
        fetch_req_ready = 1'b0; fence_done = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_valid",  {63'd0, fetch_req_valid}, 64'd0);
        chk("rst_fence",  {63'd0, fence_valid},     64'd0);
        chk("rst_sfence", {63'd0, sfence_valid},    64'd0);
        chk("rst_eepoch", {63'd0, eepoch},          64'd0);
        chk("rst_wepoch", {63'd0, wepoch},          64'd0);
        chk("rst_pc",     fetch_req_pc,             64'h1000);

        // Boot cycle, then sequential fetch with BPU predictions.
        RST_N = 1'b1;
        cyc(1'b1, 1'b0, 64'h0, 2'b00);
        chk("boot_valid", {63'd0, fetch_req_valid}, 64'd1);
        cyc(1'b1, 1'b1, 64'h1000, 2'b00);
        bpu_pred_valid = 1'b1; bpu_pred_taken = 1'b1; bpu_pred_target = 64'h2000;
        cyc(1'b1, 1'b1, 64'h1004, 2'b00);
        bpu_pred_valid = 1'b1; bpu_pred_taken = 1'b0; bpu_pred_target = 64'h7770;
        cyc(1'b1, 1'b1, 64'h2000, 2'b00);
        bpu_pred_valid = 1'b0; bpu_pred_taken = 1'b1; bpu_pred_target = 64'h7770;
        cyc(1'b1, 1'b1, 64'h2004, 2'b00);

        // Collision: writeback flush wins, only wepoch toggles.
        wb_flush_valid = 1'b1; wb_flush_pc = 64'h4000;
        ex_redirect_valid = 1'b1; ex_redirect_pc = 64'h5000;
        cyc(1'b1, 1'b1, 64'h2008, 2'b00);
        chk("coll_wepoch", {63'd0, wepoch}, 64'd1);
        chk("coll_eepoch", {63'd0, eepoch}, 64'd0);
        cyc(1'b1, 1'b1, 64'h4000, 2'b10);

        // Backpressure: ex redirect waits behind the held request.
        ex_redirect_valid = 1'b1; ex_redirect_pc = 64'h3000;
        cyc(1'b0, 1'b0, 64'h0, 2'b00);
        chk("bp_pc",     fetch_req_pc,              64'h4004);
        chk("bp_epoch",  {62'd0, fetch_req_epoch},  64'd2);
        chk("bp_eepoch", {63'd0, eepoch},           64'd1);
        bpu_pred_valid = 1'b1; bpu_pred_taken = 1'b1; bpu_pred_target = 64'h8888;
        cyc(1'b0, 1'b0, 64'h0, 2'b00);
        chk("bp_pc_hold", fetch_req_pc, 64'h4004);
        bpu_pred_valid = 1'b1; bpu_pred_taken = 1'b1; bpu_pred_target = 64'h8888;
        cyc(1'b1, 1'b1, 64'h4004, 2'b10);
        cyc(1'b1, 1'b1, 64'h3000, 2'b11);

        // A newer flush overwrites a stored redirect.
        ex_redirect_valid = 1'b1; ex_redirect_pc = 64'h5100;
        cyc(1'b0, 1'b0, 64'h0, 2'b00);
        wb_flush_valid = 1'b1; wb_flush_pc = 64'h5200;
        cyc(1'b0, 1'b0, 64'h0, 2'b00);
        chk("ovr_pc",    fetch_req_pc,             64'h3004);
        chk("ovr_epoch", {62'd0, fetch_req_epoch}, 64'd3);
        cyc(1'b1, 1'b1, 64'h3004, 2'b11);
        cyc(1'b1, 1'b1, 64'h5200, 2'b00);
        fence_done = 1'b1;
        cyc(1'b1, 1'b1, 64'h5204, 2'b00);

        // FENCE.I with a pending request: drain, fence, resume at target.
        wb_flush_valid = 1'b1; wb_flush_fence = 1'b1; wb_flush_pc = 64'h6000;
        cyc(1'b0, 1'b0, 64'h0, 2'b00);
        chk("drain_valid",  {63'd0, fetch_req_valid}, 64'd1);
        chk("drain_pc",     fetch_req_pc,             64'h5208);
        chk("drain_fence",  {63'd0, fence_valid},     64'd0);
        chk("drain_wepoch", {63'd0, wepoch},          64'd1);
        ex_redirect_valid = 1'b1; ex_redirect_pc = 64'hDEAD0;
        cyc(1'b0, 1'b0, 64'h0, 2'b00);
        chk("drain_ex_ign", {63'd0, eepoch}, 64'd0);
        cyc(1'b1, 1'b1, 64'h5208, 2'b00);
        chk("fence_on",     {63'd0, fence_valid},     64'd1);
        chk("fence_novld",  {63'd0, fetch_req_valid}, 64'd0);
        chk("fence_nosf",   {63'd0, sfence_valid},    64'd0);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0, 64'h0, 2'b00);
            chk("fence_wait", {63'd0, fence_valid}, 64'd1);
        end
        fence_done = 1'b1;
        cyc(1'b1, 1'b0, 64'h0, 2'b00);
        chk("fence_off", {63'd0, fence_valid}, 64'd0);
        chk("fence_pc",  fetch_req_pc,         64'h6000);
        cyc(1'b1, 1'b1, 64'h6000, 2'b10);

        // Both kinds set, nothing pending: straight to SFENCE.
        wb_flush_valid = 1'b1; wb_flush_fence = 1'b1; wb_flush_sfence = 1'b1; wb_flush_pc = 64'h7000;
        cyc(1'b1, 1'b1, 64'h6004, 2'b10);
        chk("sf_on",     {63'd0, sfence_valid},    64'd1);
        chk("sf_nofence",{63'd0, fence_valid},     64'd0);
        chk("sf_novld",  {63'd0, fetch_req_valid}, 64'd0);
        chk("sf_wepoch", {63'd0, wepoch},          64'd0);
        cyc(1'b1, 1'b0, 64'h0, 2'b00);
        chk("sf_hold", {63'd0, sfence_valid}, 64'd1);

        // Reset while in SFENCE.
        RST_N = 1'b0;
        cyc(1'b1, 1'b0, 64'h0, 2'b00);
        chk("rst2_sfence", {63'd0, sfence_valid},    64'd0);
        chk("rst2_valid",  {63'd0, fetch_req_valid}, 64'd0);
        chk("rst2_epochs", {62'd0, wepoch, eepoch},  64'd0);
        chk("rst2_pc",     fetch_req_pc,             64'h1000);
        RST_N = 1'b1;
        cyc(1'b1, 1'b0, 64'h0, 2'b00);
        cyc(1'b1, 1'b1, 64'h1000, 2'b00);
        cyc(1'b1, 1'b1, 64'h1004, 2'b00);
        fetch_req_ready = 1'b0;
        repeat (2) @(posedge CLK);
        chk("sb_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
